ps2_kbd_rx: RTL and testbench

PS/2 keyboard receiver and scancode decoder on `clk_sys`, placed directly downstream of the SPI user-I/O block. It samples that block's emulated `ps2_kbd_clk`/`ps2_kbd_data` pair, deframes 11-bit PS/2 frames and folds E0/F0/E1 prefixes into single key events. Those events feed the PET keyboard matrix. It also tracks Caps Lock and returns the LED state on `caps_led`, which drives the user-I/O block's `ps2_caps_led` input.

---
 rtl/ps2_kbd_rx_pkg.sv | 29 ++
 rtl/ps2_kbd_rx_filter.sv | 55 +++++
 rtl/ps2_kbd_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame states,
// scancode prefixes, the key-event record and the frame parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_REL   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] CAPS_CODE = 8'h58;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  // Odd parity over the data byte and its parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_filter.sv
// PS/2 input conditioning: two-flop synchronizers, a level filter on the
// clock line, and a registered fall pulse with the data bit captured alongside.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          level_r, fall_r, data_r;
  logic [CW-1:0] cnt_r;

  // A new clock level is taken only after it has held for FILTER cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      level_r     <= 1'b1;
      cnt_r       <= '0;
      fall_r      <= 1'b0;
      data_r      <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
      fall_r      <= 1'b0;
      if (clk_sync_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(FILTER - 1)) begin
        level_r <= clk_sync_r;
        cnt_r   <= '0;
        fall_r  <= ~clk_sync_r;
        data_r  <= data_sync_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign fall = fall_r;
  assign data = data_r;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0/E1 prefixes into
// key events and tracks Caps Lock. Define PS2_KBD_RX_FIFO_EN for a 4-entry event FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       caps_led
);

  localparam int TW = $clog2(TIMEOUT + 1);

  ps2_state_t    state_r, next_state_s;
  logic          fall_s, data_s, timeout_s, byte_done_s, ferr_s, event_s;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r, skip_r;
  logic          par_ok_r, ext_r, rel_r, held_r, caps_r, frame_err_r;
  logic [TW-1:0] to_cnt_r;
  key_event_t    evt_s;

  ps2_filter #(.FILTER(FILTER)) u_filter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall_s),
    .data     (data_s)
  );

  assign timeout_s = (state_r != IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT - 1));

  // Frame state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= next_state_s;
  end

  // Frame next-state logic; a stalled frame falls back to IDLE.
  always_comb begin
    next_state_s = state_r;
    if (timeout_s) begin
      next_state_s = IDLE;
    end else if (fall_s) begin
      case (state_r)
        IDLE:    next_state_s = data_s ? IDLE : DATA;
        DATA:    next_state_s = (bit_cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  next_state_s = STOP;
        STOP:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Frame outputs: completed byte or framing error.
  always_comb begin
    byte_done_s = 1'b0;
    ferr_s      = 1'b0;
    if (timeout_s) begin
      ferr_s = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        IDLE: ferr_s = data_s;
        STOP: begin
          if (data_s && par_ok_r) byte_done_s = 1'b1;
          else                    ferr_s      = 1'b1;
        end
        default: begin
          byte_done_s = 1'b0;
          ferr_s      = 1'b0;
        end
      endcase
    end else begin
      byte_done_s = 1'b0;
      ferr_s      = 1'b0;
    end
  end

  // Bit shifter, bit counter, parity latch and inactivity counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      par_ok_r  <= 1'b0;
      to_cnt_r  <= '0;
    end else begin
      if (state_r == IDLE || fall_s) to_cnt_r <= '0;
      else                           to_cnt_r <= to_cnt_r + TW'(1);
      if (fall_s) begin
        case (state_r)
          IDLE: bit_cnt_r <= 3'd0;
          DATA: begin
            shift_r   <= {data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          PARITY:  par_ok_r  <= odd_parity_ok(shift_r, data_s);
          default: bit_cnt_r <= bit_cnt_r;
        endcase
      end
    end
  end

  assign event_s = byte_done_s && (skip_r == 3'd0) && (shift_r != PFX_EXT) &&
                   (shift_r != PFX_REL) && (shift_r != PFX_PAUSE);
  assign evt_s   = {rel_r, ext_r, shift_r};

  // Prefix folding: E0/F0 flags, and E1 swallows the rest of the Pause sequence.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_r  <= 1'b0;
      rel_r  <= 1'b0;
      skip_r <= 3'd0;
    end else if (ferr_s) begin
      ext_r  <= 1'b0;
      rel_r  <= 1'b0;
      skip_r <= 3'd0;
    end else if (byte_done_s) begin
      if (skip_r != 3'd0) begin
        skip_r <= skip_r - 3'd1;
        ext_r  <= 1'b0;
        rel_r  <= 1'b0;
      end else begin
        case (shift_r)
          PFX_EXT: ext_r <= 1'b1;
          PFX_REL: rel_r <= 1'b1;
          PFX_PAUSE: begin
            skip_r <= PAUSE_SKIP;
            ext_r  <= 1'b0;
            rel_r  <= 1'b0;
          end
          default: begin
            ext_r <= 1'b0;
            rel_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Caps Lock toggles once per press; auto-repeat is masked until the break.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      caps_r <= 1'b0;
      held_r <= 1'b0;
    end else if (event_s && shift_r == CAPS_CODE && !ext_r) begin
      if (rel_r) begin
        held_r <= 1'b0;
      end else if (!held_r) begin
        caps_r <= ~caps_r;
        held_r <= 1'b1;
      end
    end
  end

`ifdef PS2_KBD_RX_FIFO_EN
  key_event_t fifo_mem_r [4];
  logic [1:0] wr_ptr_r, rd_ptr_r;
  logic [2:0] count_r;
  logic       push_s, pop_s, drop_s;

  assign pop_s  = (count_r != 3'd0) && key_ready;
  assign push_s = event_s && ((count_r != 3'd4) || pop_s);
  assign drop_s = event_s && !push_s;

  // Event FIFO; an event arriving while full is dropped and flagged.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) fifo_mem_r[i] <= '0;
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= ferr_s | drop_s;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= evt_s;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign key_valid                         = (count_r != 3'd0);
  assign {key_release, key_ext, key_code}  = fifo_mem_r[rd_ptr_r];
`else
  key_event_t evt_r;
  logic       key_valid_r;
  logic       unused_ready_s;

  assign unused_ready_s = key_ready;

  // Strobed event outputs; the event fields hold until the next event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_valid_r <= 1'b0;
      evt_r       <= '0;
      frame_err_r <= 1'b0;
    end else begin
      key_valid_r <= event_s;
      frame_err_r <= ferr_s;
      if (event_s) evt_r <= evt_s;
    end
  end

  assign key_valid                        = key_valid_r;
  assign {key_release, key_ext, key_code} = evt_r;
`endif

  assign frame_err = frame_err_r;
  assign caps_led  = caps_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: serialises PS/2 frames, predicts events,
// frame errors and Caps Lock from the keyboard protocol rules, and compares.
module tb_ps2_kbd_rx;

  localparam int TMO = 200;
`ifdef PS2_KBD_RX_FIFO_EN
  localparam int QCAP = 4;
`else
  localparam int QCAP = 1000;
`endif

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b1;
  logic       key_valid, key_ext, key_release, frame_err, caps_led;
  logic [7:0] key_code;

  int   checks = 0, failures = 0;
  int   exp_err = 0, err_seen = 0, events_seen = 0;
  ev_t  exp_q[$];
  logic m_ext = 1'b0, m_rel = 1'b0, m_held = 1'b0, m_caps = 1'b0;
  int   m_skip = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_ext = 1'b0, last_rel = 1'b0;

  ps2_kbd_rx #(.FILTER(4), .TIMEOUT(TMO)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_ready   (key_ready),
    .frame_err   (frame_err),
    .caps_led    (caps_led)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Model: a key event as seen by the consumer, plus the Caps Lock rule.
  task automatic model_event(input logic [7:0] code);
    if (exp_q.size() >= QCAP) exp_err++;
    else exp_q.push_back({m_rel, m_ext, code});
    if (code == 8'h58 && !m_ext) begin
      if (m_rel) m_held = 1'b0;
      else if (!m_held) begin
        m_caps = ~m_caps;
        m_held = 1'b1;
      end
    end
  endtask

  task automatic model_err();
    exp_err++;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'hE1) begin
      m_skip = 7;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      model_event(b);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    if (bad_par) model_err();
    else model_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  // Compare every consumed event against the model queue; count error strobes.
  always @(negedge clk_sys) begin : cmp
    ev_t e;
    if (reset_n) begin
      if (frame_err === 1'b1) err_seen++;
`ifdef PS2_KBD_RX_FIFO_EN
      if (key_valid === 1'b1 && key_ready === 1'b1) begin
`else
      if (key_valid === 1'b1) begin
`endif
        events_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {24'h0, key_code}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_code", {24'h0, key_code}, {24'h0, e.code});
          chk("event_ext", {31'h0, key_ext}, {31'h0, e.ext});
          chk("event_rel", {31'h0, key_release}, {31'h0, e.rel});
          last_code = key_code;
          last_ext  = key_ext;
          last_rel  = key_release;
        end
      end
    end
  end

  initial begin
    wait_cyc(5);
    chk("rst_valid", {31'h0, key_valid}, 32'd0);
    chk("rst_code", {24'h0, key_code}, 32'd0);
    chk("rst_ext", {31'h0, key_ext}, 32'd0);
    chk("rst_rel", {31'h0, key_release}, 32'd0);
    chk("rst_err", {31'h0, frame_err}, 32'd0);
    chk("rst_caps", {31'h0, caps_led}, 32'd0);
    reset_n = 1'b1;
    wait_cyc(10);

    send_byte(8'h1C, 1'b0);
    chk("t1_code", {24'h0, last_code}, 32'h1C);
    chk("t1_flags", {30'h0, last_ext, last_rel}, 32'd0);
    chk("t1_err", err_seen, 32'd0);

    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    chk("t2_prefix_silent", events_seen, 32'd1);
    send_byte(8'h75, 1'b0);
    chk("t2_code", {24'h0, last_code}, 32'h75);
    chk("t2_flags", {30'h0, last_ext, last_rel}, 32'd3);
    chk("t2_events", events_seen, 32'd2);

    send_byte(8'h1C, 1'b1);
    chk("t3_err", err_seen, 32'd1);
    chk("t3_no_event", events_seen, 32'd2);
    send_byte(8'h1C, 1'b0);
    chk("t3_recover", {24'h0, last_code}, 32'h1C);
    chk("t3_events", events_seen, 32'd3);

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    model_err();
    wait_cyc(TMO + 10);
    chk("t4_timeout_err", err_seen, 32'd2);
    send_byte(8'h58, 1'b0);
    chk("t4_caps_on", {31'h0, caps_led}, 32'd1);
    chk("t4_events", events_seen, 32'd4);

    send_byte(8'h58, 1'b0);
    chk("t5_repeat_caps", {31'h0, caps_led}, 32'd1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h58, 1'b0);
    chk("t5_break_caps", {31'h0, caps_led}, 32'd1);
    chk("t5_break_rel", {31'h0, last_rel}, 32'd1);
    send_byte(8'h58, 1'b0);
    chk("t5_caps_off", {31'h0, caps_led}, 32'd0);
    chk("t5_caps_model", {31'h0, caps_led}, {31'h0, m_caps});

    send_byte(8'hE1, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h77, 1'b0);
    chk("t6_pause_silent", events_seen, 32'd7);
    send_byte(8'h1C, 1'b0);
    chk("t6_after_pause", {24'h0, last_code}, 32'h1C);
    chk("t6_flags", {30'h0, last_ext, last_rel}, 32'd0);
    chk("t6_events", events_seen, 32'd8);

`ifdef PS2_KBD_RX_FIFO_EN
    key_ready = 1'b0;
    send_byte(8'h15, 1'b0);
    send_byte(8'h1D, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h2D, 1'b0);
    send_byte(8'h2C, 1'b0);
    chk("t7_full_err", err_seen, 32'd3);
    chk("t7_valid", {31'h0, key_valid}, 32'd1);
    chk("t7_head", {24'h0, key_code}, 32'h15);
    key_ready = 1'b1;
    repeat (4) @(negedge clk_sys);
    wait_cyc(1);
    chk("t7_drained", {31'h0, key_valid}, 32'd0);
    chk("t7_events", events_seen, 32'd12);
    chk("t7_last", {24'h0, last_code}, 32'h2D);
`endif

    wait_cyc(20);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("err_total", err_seen, exp_err);
    chk("caps_final", {31'h0, caps_led}, {31'h0, m_caps});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
